// File: rtl/mips_pkg.sv
// Shared MIPS definitions: widths, register/funct encodings and the instruction word type.
package mips_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [4:0] REG_S1 = 5'd17;
  localparam logic [4:0] REG_S2 = 5'd18;
  localparam logic [4:0] REG_T0 = 5'd8;
  localparam logic [4:0] REG_S7 = 5'd23;
  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_S0 = 5'd16;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;
  localparam logic [5:0] FUNCT_JR  = 6'h08;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [1:0]        byte_idx_t;

  // Big-endian assembly: the three earlier bytes sit above the final byte.
  function automatic inst_t be_word(input logic [3*BYTE_W-1:0] hi,
                                    input logic [BYTE_W-1:0]   lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mips_inst_fifo.sv
// Generic synchronous FIFO with a separate occupancy counter and synchronous clear.
module mips_inst_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W:0]              count_q, count_d;
  logic                        do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_q];
  assign count = count_q;

  // A push while full only lands if the same edge frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (clr) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      if (do_push) wr_d = wr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      mem_q   <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (do_push && !clr) mem_q[wr_q] <= wdata;
    end
  end

endmodule

// File: rtl/mips_inst_fetch.sv
// Byte-serial instruction fetch: big-endian word assembler, buffering FIFO and
// a single-issue output register feeding the MIPS execute stage.
module mips_inst_fetch
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [INST_W-1:0] instruction,
  output logic [PTR_W:0]    fifo_cnt,
  output logic              overflow
);

  byte_idx_t              byte_idx_q, byte_idx_d;
  logic [3*BYTE_W-1:0]    part_q, part_d;
  logic                   out_valid_q, out_valid_d;
  inst_t                  instr_q, instr_d;
  logic                   ovf_q, ovf_d;

  logic                   word_done, pop, drop;
  inst_t                  fifo_wdata, fifo_rdata;
  logic                   fifo_full, fifo_empty;
  logic [PTR_W:0]         fifo_count;

  // The fourth byte goes straight from the pins into the FIFO write port.
  assign word_done  = in_valid && (byte_idx_q == 2'd3) && !flush;
  assign fifo_wdata = be_word(part_q, in_byte);
  assign pop        = !fifo_empty && !stall && !flush;
  assign drop       = word_done && fifo_full && !pop;

  mips_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (word_done),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    byte_idx_d  = byte_idx_q;
    part_d      = part_q;
    out_valid_d = 1'b0;
    instr_d     = instr_q;
    ovf_d       = ovf_q;
    if (flush) begin
      byte_idx_d = '0;
      part_d     = '0;
      ovf_d      = 1'b0;
    end else begin
      if (in_valid) begin
        byte_idx_d = byte_idx_q + 2'd1;
        part_d     = {part_q[2*BYTE_W-1:0], in_byte};
      end
      if (pop) begin
        out_valid_d = 1'b1;
        instr_d     = fifo_rdata;
      end
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q  <= '0;
      part_q      <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      part_q      <= part_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign instruction = instr_q;
  assign fifo_cnt    = fifo_count;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mips_inst_fetch.sv
// Directed, table-driven bench for mips_inst_fetch (DEPTH=4).
module tb_mips_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] instruction;
  logic [2:0]  fifo_cnt;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        iv;
    logic [7:0]  b;
    logic        st;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_in;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    string       tag;
  } vec_t;

  vec_t vq[$];
  logic [31:0] W [1:5];

  always #5 clk = ~clk;

  mips_inst_fetch #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .stall       (stall),
    .flush       (flush),
    .out_valid   (out_valid),
    .instruction (instruction),
    .fifo_cnt    (fifo_cnt),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic ov, input logic [31:0] ins,
                     input logic [2:0] cnt, input logic ovf);
    checks++;
    if (out_valid !== ov || instruction !== ins || fifo_cnt !== cnt || overflow !== ovf) begin
      failures++;
      $display("FAIL %s: got ov=%b ins=%h cnt=%0d ovf=%b, want ov=%b ins=%h cnt=%0d ovf=%b",
               tag, out_valid, instruction, fifo_cnt, overflow, ov, ins, cnt, ovf);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] b, input logic st, input logic fl,
                     input logic ov, input logic [31:0] ins, input logic [2:0] cnt,
                     input logic ovf, input string tag);
    vec_t v;
    v.iv = iv; v.b = b; v.st = st; v.fl = fl;
    v.e_ov = ov; v.e_in = ins; v.e_cnt = cnt; v.e_ovf = ovf; v.tag = tag;
    vq.push_back(v);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic run_table();
    foreach (vq[i]) begin
      in_valid = vq[i].iv; in_byte = vq[i].b; stall = vq[i].st; flush = vq[i].fl;
      @(posedge clk); #1;
      chk($sformatf("%s[%0d]", vq[i].tag, i), vq[i].e_ov, vq[i].e_in, vq[i].e_cnt, vq[i].e_ovf);
    end
    vq.delete();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [7:0] wb(input logic [31:0] w, input int b);
    return w[31-8*b -: 8];
  endfunction

  initial begin
    logic [31:0] t1;
    t1 = 32'h20110005;
    for (int i = 1; i <= 5; i++)
      W[i] = {8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i), 8'(8'hD0 + i)};

    // reset state
    repeat (2) @(posedge clk);
    #1 chk("reset", 1'b0, 32'h0, 3'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: back-to-back bytes, issue two edges after the 4th byte
    for (int b = 0; b < 4; b++)
      add(1, wb(t1, b), 0, 0, 0, 32'h0, (b == 3) ? 3'd1 : 3'd0, 0, "t1_byte");
    add(0, 0, 0, 0, 1, t1, 0, 0, "t1_issue");
    add(0, 0, 0, 0, 0, t1, 0, 0, "t1_idle");

    // 2: three idle cycles after each byte
    for (int b = 0; b < 4; b++) begin
      add(1, wb(t1, b), 0, 0, 0, t1, (b == 3) ? 3'd1 : 3'd0, 0, "t2_byte");
      for (int g = 0; g < 3; g++)
        add(0, 0, 0, 0, (b == 3 && g == 0), t1, 0, 0, "t2_gap");
    end

    // 3: stalled fill of 5 words, the 5th is dropped, then drain 1..4
    for (int w = 1; w <= 5; w++)
      for (int b = 0; b < 4; b++)
        add(1, wb(W[w], b), 1, 0, 0, t1,
            3'((b == 3) ? ((w > 4) ? 4 : w) : ((w - 1 > 4) ? 4 : w - 1)),
            (w == 5 && b == 3), "t3_fill");
    for (int i = 1; i <= 4; i++)
      add(0, 0, 0, 0, 1, W[i], 3'(4 - i), 1, "t3_drain");
    add(0, 0, 0, 0, 0, W[4], 0, 1, "t3_sticky");
    add(0, 0, 0, 1, 0, W[4], 0, 0, "t3_flush");

    // 4: full FIFO, 5th word completes on the same edge as a pop
    for (int w = 1; w <= 4; w++)
      for (int b = 0; b < 4; b++)
        add(1, wb(W[w], b), 1, 0, 0, W[4], 3'((b == 3) ? w : w - 1), 0, "t4_fill");
    for (int b = 0; b < 3; b++)
      add(1, wb(W[5], b), 1, 0, 0, W[4], 4, 0, "t4_w5");
    add(1, wb(W[5], 3), 0, 0, 1, W[1], 4, 0, "t4_pushpop");
    for (int i = 2; i <= 5; i++)
      add(0, 0, 0, 0, 1, W[i], 3'(5 - i), 0, "t4_drain");
    add(0, 0, 0, 0, 0, W[5], 0, 0, "t4_idle");

    // 5: flush empties a non-empty FIFO and discards a partial word and its own byte
    for (int b = 0; b < 4; b++)
      add(1, wb(W[1], b), 1, 0, 0, W[5], (b == 3) ? 3'd1 : 3'd0, 0, "t5_load");
    add(0, 0, 0, 1, 0, W[5], 0, 0, "t5_flushq");
    add(0, 0, 0, 0, 0, W[5], 0, 0, "t5_noissue");
    add(1, 8'hDE, 0, 0, 0, W[5], 0, 0, "t5_part");
    add(1, 8'hAD, 0, 0, 0, W[5], 0, 0, "t5_part");
    add(1, 8'hEE, 0, 1, 0, W[5], 0, 0, "t5_flushb");
    add(1, 8'h01, 0, 0, 0, W[5], 0, 0, "t5_new");
    add(1, 8'h23, 0, 0, 0, W[5], 0, 0, "t5_new");
    add(1, 8'h45, 0, 0, 0, W[5], 0, 0, "t5_new");
    add(1, 8'h67, 0, 0, 0, W[5], 1, 0, "t5_new");
    add(0, 0, 0, 0, 1, 32'h01234567, 0, 0, "t5_issue");
    add(0, 0, 0, 0, 0, 32'h01234567, 0, 0, "t5_idle");

    // 6 setup: full + overflow, a partial word, then one issue leaves 3 words
    for (int w = 1; w <= 5; w++)
      for (int b = 0; b < 4; b++)
        add(1, wb(W[w], b), 1, 0, 0, 32'h01234567,
            3'((b == 3) ? ((w > 4) ? 4 : w) : ((w - 1 > 4) ? 4 : w - 1)),
            (w == 5 && b == 3), "t6_fill");
    add(1, 8'h99, 1, 0, 0, 32'h01234567, 4, 1, "t6_part");
    add(1, 8'h88, 1, 0, 0, 32'h01234567, 4, 1, "t6_part");
    add(0, 0, 0, 0, 1, W[1], 3, 1, "t6_pop");
    run_table();

    // 6: asynchronous reset mid-cycle, outputs clear without a clock edge
    #2 rst_n = 1'b0;
    #1 chk("t6_async", 1'b0, 32'h0, 3'd0, 1'b0);
    @(posedge clk); #1 chk("t6_held", 1'b0, 32'h0, 3'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 0, 32'h0, 0, 0, "t6_nostale");
    add(1, 8'h12, 0, 0, 0, 32'h0, 0, 0, "t6_new");
    add(1, 8'h34, 0, 0, 0, 32'h0, 0, 0, "t6_new");
    add(1, 8'h56, 0, 0, 0, 32'h0, 0, 0, "t6_new");
    add(1, 8'h78, 0, 0, 0, 32'h0, 1, 0, "t6_new");
    add(0, 0, 0, 0, 1, 32'h12345678, 0, 0, "t6_issue");
    add(0, 0, 0, 0, 0, 32'h12345678, 0, 0, "t6_idle");
    run_table();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
